// File: rtl/pu_info_fill.sv
// ----------------------------------------------------------------------------
// pu_info_fill
//   Write-side sequencer for the per-CTB neighbour-info RAM (8x8 grid of
//   entries, address = {y[2:0], x[2:0]}). One prediction-unit record is
//   accepted per handshake and its data byte is replicated into every grid
//   entry the unit covers, one RAM write per cycle, raster order.
//
//   Optional feature macro: FILL_CLEAR_EN
//     defined   -> i_clear starts a 64-entry zero fill (CLEAR state)
//     undefined -> i_clear is ignored, no CLEAR state
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_fill_valid        fill request valid
//   o_fill_ready        high in IDLE; request accepted when valid & ready
//   i_x0, i_y0          unit top-left position in 8x8 grid units
//   i_log2_size         0..3 -> unit is 1/2/4/8 grid units square
//   i_data              record byte to replicate
//   i_clear             full-grid clear request (FILL_CLEAR_EN only)
//   o_en, o_we          RAM enable / write strobe (identical)
//   o_addrd             RAM write address {cnt_y, cnt_x}
//   o_did               RAM write data
//   o_busy              sequencer not idle
//   o_done              one-cycle pulse after the last write of a fill/clear
// ----------------------------------------------------------------------------
module pu_info_fill #(
    parameter int unsigned DataBits = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_fill_valid,
    output logic                o_fill_ready,
    input  logic [2:0]          i_x0,
    input  logic [2:0]          i_y0,
    input  logic [1:0]          i_log2_size,
    input  logic [DataBits-1:0] i_data,
    input  logic                i_clear,
    output logic                o_en,
    output logic                o_we,
    output logic [5:0]          o_addrd,
    output logic [DataBits-1:0] o_did,
    output logic                o_busy,
    output logic                o_done
);

`ifdef FILL_CLEAR_EN
    typedef enum logic [1:0] {StIdle, StFill, StClear} state_e;
`else
    typedef enum logic [0:0] {StIdle, StFill} state_e;
    // Clear request has no effect in this build.
    logic w_unused_clear;
    assign w_unused_clear = i_clear;
`endif

    state_e              r_state, w_state_d;
    logic [2:0]          r_cnt_x, w_cnt_x_d;
    logic [2:0]          r_cnt_y, w_cnt_y_d;
    logic [2:0]          r_x_start, w_x_start_d;
    logic [2:0]          r_x_end, w_x_end_d;
    logic [2:0]          r_y_end, w_y_end_d;
    logic [DataBits-1:0] r_data, w_data_d;
    logic                r_done, w_done_d;

    // Extent in 4 bits so x0 + w never wraps; anything reaching past the
    // grid edge is clamped to column/row 7.
    logic [3:0] w_size;
    logic [3:0] w_x_sum;
    logic [3:0] w_y_sum;
    logic [2:0] w_x_end_new;
    logic [2:0] w_y_end_new;

    assign w_size      = 4'd1 << i_log2_size;
    assign w_x_sum     = {1'b0, i_x0} + w_size;
    assign w_y_sum     = {1'b0, i_y0} + w_size;
    assign w_x_end_new = w_x_sum[3] ? 3'd7 : (w_x_sum[2:0] - 3'd1);
    assign w_y_end_new = w_y_sum[3] ? 3'd7 : (w_y_sum[2:0] - 3'd1);

    always_comb begin
        w_state_d   = r_state;
        w_cnt_x_d   = r_cnt_x;
        w_cnt_y_d   = r_cnt_y;
        w_x_start_d = r_x_start;
        w_x_end_d   = r_x_end;
        w_y_end_d   = r_y_end;
        w_data_d    = r_data;
        w_done_d    = 1'b0;

        unique case (r_state)
            StIdle: begin
`ifdef FILL_CLEAR_EN
                // Clear wins; a simultaneous fill stays pending upstream.
                if (i_clear) begin
                    w_state_d   = StClear;
                    w_cnt_x_d   = 3'd0;
                    w_cnt_y_d   = 3'd0;
                    w_x_start_d = 3'd0;
                    w_x_end_d   = 3'd7;
                    w_y_end_d   = 3'd7;
                end else
`endif
                if (i_fill_valid) begin
                    w_state_d   = StFill;
                    w_cnt_x_d   = i_x0;
                    w_cnt_y_d   = i_y0;
                    w_x_start_d = i_x0;
                    w_x_end_d   = w_x_end_new;
                    w_y_end_d   = w_y_end_new;
                    w_data_d    = i_data;
                end
            end
            default: begin
                // Raster scan shared by FILL and CLEAR.
                if (r_cnt_x == r_x_end) begin
                    if (r_cnt_y == r_y_end) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end else begin
                        w_cnt_x_d = r_x_start;
                        w_cnt_y_d = r_cnt_y + 3'd1;
                    end
                end else begin
                    w_cnt_x_d = r_cnt_x + 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt_x   <= 3'd0;
            r_cnt_y   <= 3'd0;
            r_x_start <= 3'd0;
            r_x_end   <= 3'd0;
            r_y_end   <= 3'd0;
            r_data    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt_x   <= w_cnt_x_d;
            r_cnt_y   <= w_cnt_y_d;
            r_x_start <= w_x_start_d;
            r_x_end   <= w_x_end_d;
            r_y_end   <= w_y_end_d;
            r_data    <= w_data_d;
            r_done    <= w_done_d;
        end
    end

    // Outputs depend on registered state only.
    assign o_fill_ready = (r_state == StIdle);
    assign o_busy       = (r_state != StIdle);
    assign o_we         = (r_state != StIdle);
    assign o_en         = o_we;
    assign o_addrd      = {r_cnt_y, r_cnt_x};
    assign o_did        = (r_state == StFill) ? r_data : '0;
    assign o_done       = r_done;

endmodule

// File: tb/tb_pu_info_fill.sv
// ----------------------------------------------------------------------------
// tb_pu_info_fill
//   Directed self-checking bench for pu_info_fill. Inputs are driven 1 ns
//   after the rising edge and outputs are sampled at that same point.
//   A small RAM model captures writes for the clear/readback scenario.
// ----------------------------------------------------------------------------
module tb_pu_info_fill;

    logic       clk;
    logic       rst_n;
    logic       i_fill_valid;
    logic       o_fill_ready;
    logic [2:0] i_x0;
    logic [2:0] i_y0;
    logic [1:0] i_log2_size;
    logic [7:0] i_data;
    logic       i_clear;
    logic       o_en;
    logic       o_we;
    logic [5:0] o_addrd;
    logic [7:0] o_did;
    logic       o_busy;
    logic       o_done;

    int n_cmp;
    int n_err;

    logic [7:0] mem [64];

    pu_info_fill #(
        .DataBits(8)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_fill_valid(i_fill_valid),
        .o_fill_ready(o_fill_ready),
        .i_x0        (i_x0),
        .i_y0        (i_y0),
        .i_log2_size (i_log2_size),
        .i_data      (i_data),
        .i_clear     (i_clear),
        .o_en        (o_en),
        .o_we        (o_we),
        .o_addrd     (o_addrd),
        .o_did       (o_did),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_en && o_we) mem[o_addrd] <= o_did;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one fill (caller sits 1 ns after an edge, DUT idle) and check every
    // write against the hand-given column/row ranges, then the done pulse.
    task automatic fill_and_check(input string tag, input logic [2:0] x0,
                                  input logic [2:0] y0, input logic [1:0] lg,
                                  input logic [7:0] data, input int xs,
                                  input int xe, input int ys, input int ye);
        i_x0         = x0;
        i_y0         = y0;
        i_log2_size  = lg;
        i_data       = data;
        i_fill_valid = 1'b1;
        step();
        // Scramble inputs: they must not matter while busy.
        i_fill_valid = 1'b0;
        i_x0         = ~x0;
        i_y0         = ~y0;
        i_log2_size  = ~lg;
        i_data       = ~data;
        for (int y = ys; y <= ye; y++) begin
            for (int x = xs; x <= xe; x++) begin
                check_eq({tag, " we"}, 32'(o_we), 32'd1);
                check_eq({tag, " addr"}, 32'(o_addrd), 32'(y * 8 + x));
                check_eq({tag, " data"}, 32'(o_did), 32'(data));
                check_eq({tag, " done_low"}, 32'(o_done), 32'd0);
                step();
            end
        end
        check_eq({tag, " we_end"}, 32'(o_we), 32'd0);
        check_eq({tag, " done"}, 32'(o_done), 32'd1);
        check_eq({tag, " ready"}, 32'(o_fill_ready), 32'd1);
        step();
        check_eq({tag, " done_pulse"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        i_fill_valid = 1'b0;
        i_x0         = 3'd0;
        i_y0         = 3'd0;
        i_log2_size  = 2'd0;
        i_data       = 8'h00;
        i_clear      = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'hEE;

        // Reset state.
        step();
        check_eq("rst ready", 32'(o_fill_ready), 32'd1);
        check_eq("rst busy", 32'(o_busy), 32'd0);
        check_eq("rst we", 32'(o_we), 32'd0);
        check_eq("rst en", 32'(o_en), 32'd0);
        check_eq("rst addr", 32'(o_addrd), 32'd0);
        check_eq("rst did", 32'(o_did), 32'd0);
        check_eq("rst done", 32'(o_done), 32'd0);
        rst_n = 1'b1;
        step();
        step();

        // 16 px unit at (2,3): 0x1A, 0x1B, 0x22, 0x23.
        fill_and_check("f16", 3'd2, 3'd3, 2'd1, 8'h5A, 2, 3, 3, 4);
        // 32 px unit at (6,7): truncated to 0x3E, 0x3F.
        fill_and_check("trunc", 3'd6, 3'd7, 2'd2, 8'h11, 6, 7, 7, 7);
        // 8 px unit in the corner.
        fill_and_check("f8", 3'd7, 3'd7, 2'd0, 8'h81, 7, 7, 7, 7);
        // Full CTB: addresses 0..63 in order.
        fill_and_check("full", 3'd0, 3'd0, 2'd3, 8'hC3, 0, 7, 0, 7);

        // Back-to-back 8 px fills with valid held high.
        i_log2_size  = 2'd0;
        i_y0         = 3'd0;
        i_x0         = 3'd0;
        i_data       = 8'h01;
        i_fill_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("b2b we", 32'(o_we), 32'd1);
            check_eq("b2b addr", 32'(o_addrd), 32'(k));
            check_eq("b2b data", 32'(o_did), 32'(k + 1));
            check_eq("b2b done_low", 32'(o_done), 32'd0);
            i_x0   = 3'(k + 1);
            i_data = 8'(k + 2);
            step();
            check_eq("b2b gap we", 32'(o_we), 32'd0);
            check_eq("b2b done", 32'(o_done), 32'd1);
        end
        i_fill_valid = 1'b0;
        step();
        check_eq("b2b tail done", 32'(o_done), 32'd0);

`ifdef FILL_CLEAR_EN
        // Clear and fill together: clear runs first, fill follows o_done.
        i_clear      = 1'b1;
        i_fill_valid = 1'b1;
        i_x0         = 3'd1;
        i_y0         = 3'd1;
        i_log2_size  = 2'd1;
        i_data       = 8'hAA;
        step();
        i_clear = 1'b0;
        check_eq("clr ready", 32'(o_fill_ready), 32'd0);
        for (int i = 0; i < 64; i++) begin
            check_eq("clr we", 32'(o_we), 32'd1);
            check_eq("clr addr", 32'(o_addrd), 32'(i));
            check_eq("clr data", 32'(o_did), 32'd0);
            step();
        end
        check_eq("clr done", 32'(o_done), 32'd1);
        check_eq("clr busy", 32'(o_busy), 32'd0);
        check_eq("clr ready_end", 32'(o_fill_ready), 32'd1);
        step();
        i_fill_valid = 1'b0;
        check_eq("cf addr0", 32'(o_addrd), 32'h09);
        check_eq("cf data0", 32'(o_did), 32'hAA);
        step();
        check_eq("cf addr1", 32'(o_addrd), 32'h0A);
        step();
        check_eq("cf addr2", 32'(o_addrd), 32'h11);
        step();
        check_eq("cf addr3", 32'(o_addrd), 32'h12);
        step();
        check_eq("cf done", 32'(o_done), 32'd1);
        for (int i = 0; i < 64; i++) begin
            check_eq("ram rb", 32'(mem[i]),
                     (i == 9 || i == 10 || i == 17 || i == 18) ? 32'hAA : 32'h00);
        end
        step();
`else
        // Clear ignored: nothing starts.
        i_clear = 1'b1;
        step();
        check_eq("noclr busy", 32'(o_busy), 32'd0);
        check_eq("noclr we", 32'(o_we), 32'd0);
        // Clear with fill: fill accepted at once.
        i_fill_valid = 1'b1;
        i_x0         = 3'd1;
        i_y0         = 3'd1;
        i_log2_size  = 2'd0;
        i_data       = 8'hAA;
        step();
        i_fill_valid = 1'b0;
        i_clear      = 1'b0;
        check_eq("noclr fill addr", 32'(o_addrd), 32'h09);
        check_eq("noclr fill data", 32'(o_did), 32'hAA);
        step();
        check_eq("noclr done", 32'(o_done), 32'd1);
        step();
`endif

        // Reset asserted mid-FILL takes effect without a clock edge.
        i_x0         = 3'd0;
        i_y0         = 3'd0;
        i_log2_size  = 2'd3;
        i_data       = 8'h77;
        i_fill_valid = 1'b1;
        step();
        i_fill_valid = 1'b0;
        step();
        step();
        check_eq("mid busy", 32'(o_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst we", 32'(o_we), 32'd0);
        check_eq("mrst busy", 32'(o_busy), 32'd0);
        check_eq("mrst ready", 32'(o_fill_ready), 32'd1);
        check_eq("mrst did", 32'(o_did), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_eq("post rst we", 32'(o_we), 32'd0);
        fill_and_check("post", 3'd4, 3'd4, 2'd1, 8'h3C, 4, 5, 4, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pu_info_fill.md
# pu_info_fill

Write-side sequencer for the per-CTB neighbour-info distributed RAM (intra pred mode, ref_idx, mvp flags). Accepts one prediction-unit record per handshake: position, size and data byte. Replicates the byte into every 8x8 grid entry the unit covers, one RAM write per cycle. Optionally clears the whole grid at CTB start. Sits directly upstream of the 64-entry write port; neighbour lookups use the RAM's asynchronous read port untouched.

## Interface
- addr_bits, 6, RAM address width; fixed grid of 8x8 entries, address = {y[2:0], x[2:0]}
- data_bits, 8, stored record width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_fill_valid  in  1  fill request valid
- o_fill_ready  out  1  = (state==IDLE)
- i_x0  in  3  unit left column, 8x8 grid units
- i_y0  in  3  unit top row, 8x8 grid units
- i_log2_size  in  2  0/1/2/3 -> width=height 1/2/4/8 units (8/16/32/64 px)
- i_data  in  data_bits  record to replicate
- i_clear  in  1  request full-grid clear (only with FILL_CLEAR_EN)
- o_en  out  1  RAM enable, equals o_we
- o_we  out  1  RAM write strobe
- o_addrd  out  addr_bits  RAM write address {cnt_y, cnt_x}
- o_did  out  data_bits  RAM write data
- o_busy  out  1  = (state!=IDLE)
- o_done  out  1  one-cycle pulse after the last write of a fill or clear

## Operation
- States: IDLE, FILL, CLEAR. Reset -> IDLE, counters 0, latched data 0, o_done 0. Resulting outputs: o_fill_ready=1, o_busy=0, o_we=o_en=0, o_addrd=0, o_did=0.
- IDLE, i_clear=1 (macro on):
  - go to CLEAR, cnt_x=cnt_y=0.
  - Clear wins over a simultaneous i_fill_valid; that fill is not accepted, and the source holds valid.
- IDLE, i_fill_valid=1 and no clear: accept.
  - Latch i_data, x_start=i_x0, x_end, y_end.
  - cnt_x=i_x0, cnt_y=i_y0; go to FILL.
- Extent arithmetic in 4 bits: w = 1<<i_log2_size; x_end = min(i_x0+w, 8)-1; y_end likewise with i_y0.
  - Units crossing the grid edge are truncated, never wrapped. Example: x0=6, size 32 px -> columns 6..7 only.
- FILL: o_we=1, o_addrd={cnt_y,cnt_x}, o_did=latched data.
  - Raster scan: cnt_x++ until x_end, then cnt_x=x_start and cnt_y++.
  - After the write at (x_end, y_end): go to IDLE, set o_done for one cycle.
- CLEAR: same scan over all 64 entries, o_did=0, then IDLE plus o_done.
- Inputs are ignored while busy. i_x0, i_y0, i_log2_size and i_data need only be valid in the accept cycle.
- Reset mid-FILL or mid-CLEAR: immediate return to IDLE and o_we=0. Partially written RAM contents are not restored.

## Timing
- Accept at edge k. First write presented in cycle k+1 and captured by the RAM at edge k+2.
- N = w_eff*h_eff writes on consecutive cycles, no bubbles.
- o_done high in cycle k+1+N, the first IDLE cycle; o_fill_ready is 1 in that same cycle.
- A new request may be accepted at the edge ending the o_done cycle, so back-to-back fills lose exactly one cycle.
- A clear takes 64 write cycles plus the done cycle.
- o_we, o_addrd and o_did are decoded from registered state and counters only; no input-to-output combinational path.

## Configuration
- FILL_CLEAR_EN defined: CLEAR state and i_clear are active as above.
- FILL_CLEAR_EN undefined: i_clear is ignored, the CLEAR state is absent, and the grid retains old contents across CTBs; the upstream stage overwrites every entry it later reads.

## Test plan
- Reset: hold rst_n=0 mid-FILL -> o_we=0, o_busy=0, o_fill_ready=1 in the same cycle.
- Fill x0=2, y0=3, size 16 px (log2=1), data 0x5A -> writes at 0x1A, 0x1B, 0x22, 0x23 on 4 consecutive cycles; o_done in cycle 5 after accept.
- Edge truncation, x0=6, y0=7, size 32 px, data 0x11 -> 2 writes only (0x3E, 0x3F), o_done next cycle, no address wrap.
- Full CTB, x0=0, y0=0, size 64 px, data 0xC3 -> 64 writes, addresses 0..63 in order.
- Clear and fill asserted together in IDLE (macro on) -> 64 zero writes first; fill accepted the cycle after o_done, and the RAM reads back the fill data in its region and 0 elsewhere.
- Back-to-back 8 px fills with valid held high -> one write every two cycles; each o_done pulse is 1 cycle wide.
